// File: rtl/psr_save_restore.sv
// PSR save/restore sequencer: pushes the PSR and vectors on an accepted interrupt,
// and pops/restores the PSR on RTI (supervisor only; user-mode RTI faults).
module psr_save_restore (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  nzp_in,
  input  logic        int_req,
  input  logic [2:0]  int_prio,
  input  logic [7:0]  int_vec,
  input  logic        rti_req,
  input  logic [15:0] bus_in,
  input  logic        mem_ready,
  output logic [15:0] bus_out,
  output logic        bus_out_en,
  output logic        mem_wr,
  output logic        mem_rd,
  output logic        psr_mux_sel,
  output logic        ld_cc,
  output logic        priv,
  output logic [2:0]  prio,
  output logic [15:0] vec_addr,
  output logic        int_ack,
  output logic        rti_done,
  output logic        rti_fault,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_PUSH, S_SETPSR, S_VECTOR, S_POP, S_RESTORE, S_FAULT
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_int_ok;
  logic        r_priv;
  logic [2:0]  r_prio;
  logic [2:0]  r_int_prio;
  logic [7:0]  r_vec;
  logic [15:0] r_psr;
  logic        r_bus_out_en, r_mem_wr, r_mem_rd, r_restore;
  logic        r_int_ack, r_rti_fault, r_busy;

  assign w_int_ok = int_req && (int_prio > r_prio);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_int_ok)     w_next = S_PUSH;
        else if (rti_req) w_next = r_priv ? S_FAULT : S_POP;
      end
      S_PUSH:    if (mem_ready) w_next = S_SETPSR;
      S_SETPSR:  w_next = S_VECTOR;
      S_VECTOR:  w_next = S_IDLE;
      S_POP:     if (mem_ready) w_next = S_RESTORE;
      S_RESTORE: w_next = S_IDLE;
      S_FAULT:   w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Strobes are flops loaded from the next state, so each is high exactly while in its state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bus_out_en <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_mem_rd     <= 1'b0;
      r_restore    <= 1'b0;
      r_int_ack    <= 1'b0;
      r_rti_fault  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_bus_out_en <= (w_next == S_PUSH) || (w_next == S_RESTORE);
      r_mem_wr     <= (w_next == S_PUSH);
      r_mem_rd     <= (w_next == S_POP);
      r_restore    <= (w_next == S_RESTORE);
      r_int_ack    <= (w_next == S_VECTOR);
      r_rti_fault  <= (w_next == S_FAULT);
      r_busy       <= (w_next != S_IDLE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_priv     <= 1'b0;
      r_prio     <= 3'b000;
      r_int_prio <= 3'b000;
      r_vec      <= 8'h00;
      r_psr      <= 16'h0000;
    end else begin
      if (r_state == S_IDLE && w_int_ok) begin
        r_int_prio <= int_prio;
        r_vec      <= int_vec;
      end
      if (r_state == S_POP && mem_ready) r_psr <= bus_in;
      if (r_state == S_SETPSR) begin
        r_priv <= 1'b0;
        r_prio <= r_int_prio;
      end else if (r_state == S_RESTORE) begin
        r_priv <= r_psr[15];
        r_prio <= r_psr[10:8];
      end
    end
  end

  // PUSH drives the live PSR image; RESTORE drives the captured word back to the CC register.
  always_comb begin
    bus_out = 16'h0000;
    if (r_bus_out_en) begin
      if (r_restore) bus_out = r_psr;
      else           bus_out = {r_priv, 4'b0000, r_prio, 5'b00000, nzp_in};
    end
  end

  assign vec_addr    = {8'h01, r_vec};
  assign bus_out_en  = r_bus_out_en;
  assign mem_wr      = r_mem_wr;
  assign mem_rd      = r_mem_rd;
  assign psr_mux_sel = r_restore;
  assign ld_cc       = r_restore;
  assign rti_done    = r_restore;
  assign int_ack     = r_int_ack;
  assign rti_fault   = r_rti_fault;
  assign busy        = r_busy;
  assign priv        = r_priv;
  assign prio        = r_prio;

endmodule

// File: tb/tb_psr_save_restore.sv
// Directed bench for psr_save_restore: expectations are queued as stimulus is
// applied and popped in order as the DUT reaches each observation point.
module tb_psr_save_restore;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  nzp_in;
  logic        int_req;
  logic [2:0]  int_prio;
  logic [7:0]  int_vec;
  logic        rti_req;
  logic [15:0] bus_in;
  logic        mem_ready;
  logic [15:0] bus_out;
  logic        bus_out_en, mem_wr, mem_rd, psr_mux_sel, ld_cc, priv;
  logic [2:0]  prio;
  logic [15:0] vec_addr;
  logic        int_ack, rti_done, rti_fault, busy;

  psr_save_restore dut (
    .clk(clk), .rst(rst), .nzp_in(nzp_in), .int_req(int_req), .int_prio(int_prio),
    .int_vec(int_vec), .rti_req(rti_req), .bus_in(bus_in), .mem_ready(mem_ready),
    .bus_out(bus_out), .bus_out_en(bus_out_en), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .psr_mux_sel(psr_mux_sel), .ld_cc(ld_cc), .priv(priv), .prio(prio),
    .vec_addr(vec_addr), .int_ack(int_ack), .rti_done(rti_done),
    .rti_fault(rti_fault), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic push(input string tag, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [15:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_underflow observed=%h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   nrd;
    logic noisy;

    rst = 1'b1; nzp_in = 3'b000; int_req = 1'b0; int_prio = 3'd0; int_vec = 8'h00;
    rti_req = 1'b0; bus_in = 16'h0000; mem_ready = 1'b0;

    // Reset state
    push("rst_busy", 16'd0); push("rst_priv", 16'd0); push("rst_prio", 16'd0);
    push("rst_mem_wr", 16'd0); push("rst_mem_rd", 16'd0);
    push("rst_bus_out_en", 16'd0); push("rst_bus_out", 16'h0000); push("rst_int_ack", 16'd0);
    repeat (2) step();
    chk(16'(busy)); chk(16'(priv)); chk(16'(prio));
    chk(16'(mem_wr)); chk(16'(mem_rd));
    chk(16'(bus_out_en)); chk(bus_out); chk(16'(int_ack));
    rst = 1'b0;
    step();

    // Interrupt at prio 0, zero-wait memory
    nzp_in = 3'b010; int_vec = 8'h80; int_prio = 3'd4; mem_ready = 1'b1; int_req = 1'b1;
    push("t1_mem_wr", 16'd1); push("t1_bus_out", 16'h0002);
    push("t1_prio_in_setpsr", 16'd0);
    push("t1_int_ack", 16'd1); push("t1_vec_addr", 16'h0180);
    push("t1_prio", 16'd4); push("t1_priv", 16'd0); push("t1_idle_busy", 16'd0);
    step(); chk(16'(mem_wr)); chk(bus_out);
    step(); chk(16'(prio));
    step(); chk(16'(int_ack)); chk(vec_addr); chk(16'(prio)); chk(16'(priv));
    int_req = 1'b0;
    step(); chk(16'(busy));

    // Equal priority is refused; higher priority is accepted
    int_prio = 3'd4; int_vec = 8'h3C; int_req = 1'b1;
    push("t2_equal_busy", 16'd0); push("t2_equal_mem_wr", 16'd0);
    repeat (3) step();
    chk(16'(busy)); chk(16'(mem_wr));
    int_prio = 3'd5;
    push("t2_busy", 16'd1); push("t2_int_ack", 16'd1); push("t2_vec_addr", 16'h013C);
    push("t2_prio", 16'd5);
    step(); chk(16'(busy));
    step(); step(); chk(16'(int_ack)); chk(vec_addr);
    int_req = 1'b0;
    step(); chk(16'(prio));

    // Supervisor RTI with 3 wait cycles
    bus_in = 16'h8304; mem_ready = 1'b0; rti_req = 1'b1;
    push("t3_mem_rd_cycles", 16'd4); push("t3_ld_cc", 16'd1); push("t3_psr_mux_sel", 16'd1);
    push("t3_rti_done", 16'd1); push("t3_bus_out_en", 16'd1); push("t3_nzp", 16'd4);
    push("t3_priv", 16'd1); push("t3_prio", 16'd3);
    nrd = 0;
    repeat (4) begin
      step();
      if (mem_rd) nrd++;
    end
    mem_ready = 1'b1;
    step();
    if (mem_rd) nrd++;
    chk(16'(nrd)); chk(16'(ld_cc)); chk(16'(psr_mux_sel)); chk(16'(rti_done));
    chk(16'(bus_out_en)); chk({13'd0, bus_out[2:0]});
    rti_req = 1'b0;
    step(); chk(16'(priv)); chk(16'(prio));

    // User-mode RTI faults
    rti_req = 1'b1;
    push("t4_rti_fault", 16'd1); push("t4_mem_rd", 16'd0);
    push("t4_fault_len", 16'd0); push("t4_mem_rd_after", 16'd0);
    push("t4_priv", 16'd1); push("t4_prio", 16'd3); push("t4_busy", 16'd0);
    step(); chk(16'(rti_fault)); chk(16'(mem_rd));
    rti_req = 1'b0;
    step(); chk(16'(rti_fault)); chk(16'(mem_rd)); chk(16'(priv)); chk(16'(prio)); chk(16'(busy));

    // Simultaneous interrupt and RTI from prio 0: interrupt first
    rst = 1'b1; step(); rst = 1'b0; step();
    int_prio = 3'd2; int_vec = 8'h22; bus_in = 16'h0001; mem_ready = 1'b1;
    int_req = 1'b1; rti_req = 1'b1;
    push("t5_mem_wr", 16'd1); push("t5_mem_rd", 16'd0);
    push("t5_int_ack", 16'd1); push("t5_vec_addr", 16'h0122);
    push("t5_idle_busy", 16'd0); push("t5_prio_after_int", 16'd2);
    push("t5_pop_mem_rd", 16'd1); push("t5_rti_done", 16'd1); push("t5_nzp", 16'd1);
    push("t5_prio", 16'd0); push("t5_priv", 16'd0); push("t5_busy", 16'd0);
    step(); chk(16'(mem_wr)); chk(16'(mem_rd));
    step(); step(); chk(16'(int_ack)); chk(vec_addr);
    int_req = 1'b0;
    step(); chk(16'(busy)); chk(16'(prio));
    step(); chk(16'(mem_rd));
    step(); chk(16'(rti_done)); chk({13'd0, bus_out[2:0]});
    rti_req = 1'b0;
    step(); chk(16'(prio)); chk(16'(priv)); chk(16'(busy));

    // Reset in PUSH while memory stalls
    int_prio = 3'd1; int_vec = 8'h55; nzp_in = 3'b001; mem_ready = 1'b0; int_req = 1'b1;
    push("t6_mem_wr", 16'd1);
    push("t6_rst_mem_wr", 16'd0); push("t6_rst_bus_out_en", 16'd0);
    push("t6_rst_bus_out", 16'h0000); push("t6_rst_busy", 16'd0);
    push("t6_rst_prio", 16'd0); push("t6_rst_priv", 16'd0); push("t6_quiet", 16'd0);
    step(); chk(16'(mem_wr));
    rst = 1'b1;
    #1;
    chk(16'(mem_wr)); chk(16'(bus_out_en)); chk(bus_out); chk(16'(busy));
    chk(16'(prio)); chk(16'(priv));
    int_req = 1'b0; mem_ready = 1'b1;
    step(); rst = 1'b0;
    noisy = 1'b0;
    repeat (4) begin
      step();
      if (mem_wr || mem_rd || bus_out_en || busy || int_ack) noisy = 1'b1;
    end
    chk(16'(noisy));

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/psr_save_restore.md
PSR_SAVE_RESTORE -- requirements
Module: psr_save_restore

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: single clock, all state on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 The block SHALL have the port nzp_in, input, 3 bits: current {N,Z,P} from the condition-code register.
REQ-004 The block SHALL have the port int_req, input, 1 bit: level interrupt request, held by the source until int_ack.
REQ-005 The block SHALL have the port int_prio, input, 3 bits: priority of the requesting interrupt.
REQ-006 The block SHALL have the port int_vec, input, 8 bits: interrupt vector number.
REQ-007 The block SHALL have the port rti_req, input, 1 bit: level RTI request, held until rti_done or rti_fault.
REQ-008 The block SHALL have the port bus_in, input, 16 bits: data bus read value, valid when mem_ready=1.
REQ-009 The block SHALL have the port mem_ready, input, 1 bit: memory completes the current mem_wr or mem_rd.
REQ-010 The block SHALL have the port bus_out, output, 16 bits: PSR image {priv,4'b0,prio,5'b0,nzp_in}, 16'h0000 when bus_out_en=0.
REQ-011 The block SHALL have the port bus_out_en, output, 1 bit: bus drive enable.
REQ-012 The block SHALL have the ports mem_wr and mem_rd, outputs, 1 bit each: memory write and read strobes.
REQ-013 The block SHALL have the ports psr_mux_sel and ld_cc, outputs, 1 bit each: control the condition-code register to load NZP from bus_in[2:0].
REQ-014 The block SHALL have the ports priv (1 bit) and prio (3 bits), outputs: privilege (0=supervisor, 1=user) and current priority.
REQ-015 The block SHALL have the port vec_addr, output, 16 bits: {8'h01,int_vec_latched}, valid while int_ack=1.
REQ-016 The block SHALL have the ports int_ack, rti_done, rti_fault and busy, outputs, 1 bit each.

Function
REQ-017 The FSM SHALL have the states IDLE, PUSH, SETPSR, VECTOR, POP, RESTORE and FAULT, and busy SHALL be 1 in every state except IDLE.
REQ-018 In IDLE, an interrupt SHALL be accepted only if int_req=1 and int_prio>prio, an unsigned 3-bit compare; on acceptance the block latches int_prio and int_vec and moves to PUSH.
REQ-019 In IDLE, if both int_req and rti_req are 1 and the interrupt is acceptable, the interrupt SHALL win; otherwise the RTI is serviced.
REQ-020 On rti_req in IDLE with priv=1, the block SHALL go to FAULT, assert rti_fault for 1 cycle, leave priv, prio and the bus untouched, and return to IDLE.
REQ-021 On rti_req in IDLE with priv=0, the block SHALL go to POP.
REQ-022 In PUSH, bus_out_en and mem_wr SHALL be 1 and bus_out SHALL be the PSR image from the pre-interrupt priv and prio; the block stays until mem_ready=1, then moves to SETPSR.
REQ-023 In SETPSR, lasting 1 cycle, priv SHALL become 0 and prio SHALL become the latched int_prio, both visible the next cycle, and the block moves to VECTOR.
REQ-024 In VECTOR, lasting 1 cycle, int_ack SHALL be 1 with vec_addr valid, and the block returns to IDLE.
REQ-025 In POP, mem_rd SHALL be 1 until mem_ready=1; in the mem_ready cycle the block captures bus_in and moves to RESTORE.
REQ-026 In RESTORE, lasting 1 cycle, psr_mux_sel=1, ld_cc=1 and rti_done=1; bus_out_en=1 with bus_out[2:0]=captured NZP; priv:=captured[15] and prio:=captured[10:8]; the block then returns to IDLE.
REQ-027 Outside RESTORE, psr_mux_sel and ld_cc SHALL be 0.
REQ-028 Requests SHALL be ignored in every non-IDLE state.
REQ-029 A request still asserted when the FSM returns to IDLE SHALL be re-evaluated against the updated prio and priv.
REQ-030 mem_ready SHALL be ignored outside PUSH and POP.
REQ-031 All outputs except bus_out and vec_addr SHALL be registered.
REQ-032 Latency SHALL be: interrupt with mem_ready tied to 1 reaches int_ack 3 cycles after acceptance; RTI with mem_ready tied to 1 reaches rti_done 2 cycles after acceptance.

Reset
REQ-033 While rst=1, state SHALL be IDLE, priv=0, prio=3'b000, the latched vector and captured PSR SHALL be 0, and all strobes, busy and bus_out_en SHALL be 0.
REQ-034 rst asserted mid-sequence, including during PUSH or POP, SHALL abort the sequence immediately, with no further strobes after reset deasserts.

Verification
REQ-035 Bench: prio=0, int_req=1, int_prio=4, int_vec=8'h80, nzp_in=3'b010, mem_ready=1 -> bus_out=16'h0002 with mem_wr, then priv=0, prio=4, int_ack with vec_addr=16'h0180.
REQ-036 Bench: prio=4, int_req=1 with int_prio=4 -> no acceptance, busy stays 0; int_prio changed to 5 -> accepted.
REQ-037 Bench: priv=0, rti_req=1, mem_ready delayed 3 cycles, bus_in=16'h8304 -> mem_rd for 4 cycles, then RESTORE with ld_cc=1, psr_mux_sel=1, NZP=3'b100, priv=1, prio=3.
REQ-038 Bench: priv=1, rti_req=1 -> rti_fault 1 cycle, mem_rd never asserted, priv and prio unchanged.
REQ-039 Bench: int_req (int_prio=2) and rti_req asserted together at prio=0 -> interrupt sequence first; RTI serviced after return to IDLE.
REQ-040 Bench: rst asserted in PUSH while mem_ready=0 -> mem_wr and bus_out_en drop at once; priv=0, prio=0, state IDLE.
